// File: rtl/reg_wb_unit_if.sv
// Write-back bundle: decode scoreboard port, ALU and load result channels, reg_file write port.
// The DUT takes the slave modport; producers/consumers around it take master.
interface reg_wb_unit_if;
   logic        sb_set;
   logic [4:0]  sb_rd;
   logic [31:0] busy;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic [4:0]  rf_wreg;
   logic [31:0] rf_wdata;
   logic        rf_w_en;

   modport master (
      output sb_set, sb_rd, alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
      input  busy, alu_ready, ld_ready, rf_wreg, rf_wdata, rf_w_en
   );

   modport slave (
      input  sb_set, sb_rd, alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
      output busy, alu_ready, ld_ready, rf_wreg, rf_wdata, rf_w_en
   );
endinterface

// File: rtl/reg_wb_unit.sv
// Merges ALU and FIFO-buffered load results into one reg_file write per cycle (grant N -> write N+1).
// Loads stall via ld_ready when the FIFO is full; ALU stalls via alu_ready after STARVE_MAX wins over waiting loads.
module reg_wb_unit #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 4
) (
   input logic          clk,
   input logic          rst,
   reg_wb_unit_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_ent_t;

   wb_ent_t        mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic [SW-1:0]  starve_cnt;
   logic [31:0]    busy_q;
   logic [31:0]    busy_nxt;
   logic           fifo_empty;
   logic           push;
   logic           pop;
   logic           alu_grant;
   logic           grant;
   logic           wr_real;
   wb_ent_t        win;

   assign fifo_empty    = (count == '0);
   assign bus.ld_ready  = (count < CW'(DEPTH));
   assign bus.alu_ready = (starve_cnt != SW'(STARVE_MAX));
   assign push          = bus.ld_valid & bus.ld_ready;
   assign alu_grant     = bus.alu_valid & bus.alu_ready;
   assign pop           = !alu_grant && !fifo_empty;
   assign grant         = alu_grant | pop;
   assign wr_real       = grant && (win.rd != 5'd0);
   assign bus.busy      = busy_q;

   always_comb begin
      win = mem[rd_ptr];
      if (alu_grant) begin
         win.rd   = bus.alu_rd;
         win.data = bus.alu_data;
      end
   end

   // Set after clear so a same-cycle issue to the retiring register keeps it busy.
   always_comb begin
      busy_nxt = busy_q;
      if (wr_real) begin
         busy_nxt[win.rd] = 1'b0;
      end
      if (bus.sb_set && (bus.sb_rd != 5'd0)) begin
         busy_nxt[bus.sb_rd] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{rd: bus.ld_rd, data: bus.ld_data};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         starve_cnt   <= '0;
         busy_q       <= 32'h0;
         bus.rf_w_en  <= 1'b0;
         bus.rf_wreg  <= 5'd0;
         bus.rf_wdata <= 32'h0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         // Only ALU wins over a waiting load count toward forcing the FIFO through.
         if (alu_grant && !fifo_empty) begin
            starve_cnt <= starve_cnt + 1'b1;
         end else begin
            starve_cnt <= '0;
         end

         busy_q      <= busy_nxt;
         bus.rf_w_en <= wr_real;
         if (wr_real) begin
            bus.rf_wreg  <= win.rd;
            bus.rf_wdata <= win.data;
         end
      end
   end
endmodule

// File: tb/tb_reg_wb_unit.sv
// Directed bench for reg_wb_unit: inputs driven 1 time unit after posedge, outputs sampled there too.
module tb_reg_wb_unit;
   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   reg_wb_unit_if bus ();

   reg_wb_unit #(.DEPTH(4), .STARVE_MAX(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.sb_set    = 1'b0;
      bus.sb_rd     = 5'd0;
      bus.alu_valid = 1'b0;
      bus.alu_rd    = 5'd0;
      bus.alu_data  = 32'h0;
      bus.ld_valid  = 1'b0;
      bus.ld_rd     = 5'd0;
      bus.ld_data   = 32'h0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle_inputs();
      #1;
      n_assert++;
      if (bus.rf_w_en !== 1'b0 || bus.busy !== 32'h0 || bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
         $display("FAIL reset_state: w_en=%b busy=%h ld_ready=%b alu_ready=%b, want 0/0/1/1",
                  bus.rf_w_en, bus.busy, bus.ld_ready, bus.alu_ready);
         n_fail++;
      end
      tick();
      tick();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_assert++;
         if (bus.rf_w_en !== 1'b0 || bus.busy !== 32'h0 || bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1
             || bus.rf_wreg !== 5'd0 || bus.rf_wdata !== 32'h0) begin
            $display("FAIL idle_cycle%0d: w_en=%b busy=%h ld_ready=%b alu_ready=%b wreg=%0d wdata=%h, want idle zeros",
                     c, bus.rf_w_en, bus.busy, bus.ld_ready, bus.alu_ready, bus.rf_wreg, bus.rf_wdata);
            n_fail++;
         end
      end
   endtask

   task automatic test_scoreboard;
      bus.sb_set = 1'b1;
      bus.sb_rd  = 5'd5;
      tick();
      bus.sb_set = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         n_assert++;
         if (bus.busy !== 32'h20) begin
            $display("FAIL sb_busy5_cycle%0d: busy=%h, want 00000020", c, bus.busy);
            n_fail++;
         end
         if (c == 3) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'd5;
            bus.alu_data  = 32'h1234;
            n_assert++;
            if (bus.alu_ready !== 1'b1) begin
               $display("FAIL sb_alu_ready: got %b, want 1", bus.alu_ready);
               n_fail++;
            end
         end
         tick();
      end
      n_assert++;
      if (bus.rf_w_en !== 1'b1 || bus.rf_wreg !== 5'd5 || bus.rf_wdata !== 32'h1234 || bus.busy !== 32'h0) begin
         $display("FAIL sb_alu_write: w_en=%b wreg=%0d wdata=%h busy=%h, want 1/5/00001234/0",
                  bus.rf_w_en, bus.rf_wreg, bus.rf_wdata, bus.busy);
         n_fail++;
      end
      bus.alu_valid = 1'b0;
      tick();
      n_assert++;
      if (bus.rf_w_en !== 1'b0 || bus.rf_wreg !== 5'd5 || bus.rf_wdata !== 32'h1234) begin
         $display("FAIL sb_hold: w_en=%b wreg=%0d wdata=%h, want 0/5/00001234",
                  bus.rf_w_en, bus.rf_wreg, bus.rf_wdata);
         n_fail++;
      end
   endtask

   // ALU grants to r0 keep the FIFO from draining so it fills to DEPTH.
   task automatic test_load_fifo;
      for (int i = 0; i < 4; i++) begin
         n_assert++;
         if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
            $display("FAIL fill_ready%0d: ld_ready=%b alu_ready=%b, want 1/1", i, bus.ld_ready, bus.alu_ready);
            n_fail++;
         end
         bus.ld_valid  = 1'b1;
         bus.ld_rd     = 5'(i + 1);
         bus.ld_data   = 32'hA0 + 32'(i);
         bus.alu_valid = 1'b1;
         bus.alu_rd    = 5'd0;
         bus.alu_data  = 32'hFFFF;
         tick();
         n_assert++;
         if (bus.rf_w_en !== 1'b0) begin
            $display("FAIL fill_no_write%0d: w_en=%b, want 0", i, bus.rf_w_en);
            n_fail++;
         end
      end
      n_assert++;
      if (bus.ld_ready !== 1'b0) begin
         $display("FAIL full_ld_ready: got %b, want 0", bus.ld_ready);
         n_fail++;
      end
      bus.alu_valid = 1'b0;
      bus.ld_rd     = 5'd9;
      bus.ld_data   = 32'hBAD;
      tick();
      n_assert++;
      if (bus.ld_ready !== 1'b1) begin
         $display("FAIL after_pop_ld_ready: got %b, want 1", bus.ld_ready);
         n_fail++;
      end
      bus.ld_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n_assert++;
         if (bus.rf_w_en !== 1'b1 || bus.rf_wreg !== 5'(k + 1) || bus.rf_wdata !== 32'hA0 + 32'(k)) begin
            $display("FAIL load_order%0d: w_en=%b wreg=%0d wdata=%h, want 1/%0d/%h",
                     k, bus.rf_w_en, bus.rf_wreg, bus.rf_wdata, k + 1, 32'hA0 + 32'(k));
            n_fail++;
         end
         tick();
      end
      n_assert++;
      if (bus.rf_w_en !== 1'b0) begin
         $display("FAIL rejected_load_written: w_en=%b wreg=%0d, want 0", bus.rf_w_en, bus.rf_wreg);
         n_fail++;
      end
   endtask

   task automatic test_reg0_and_set_wins;
      bus.sb_set = 1'b1;
      bus.sb_rd  = 5'd7;
      tick();
      n_assert++;
      if (bus.busy !== 32'h80) begin
         $display("FAIL r7_set: busy=%h, want 00000080", bus.busy);
         n_fail++;
      end
      bus.sb_rd     = 5'd0;
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd0;
      bus.alu_data  = 32'hFFFF;
      tick();
      n_assert++;
      if (bus.rf_w_en !== 1'b0 || bus.busy !== 32'h80) begin
         $display("FAIL r0_write: w_en=%b busy=%h, want 0/00000080", bus.rf_w_en, bus.busy);
         n_fail++;
      end
      bus.sb_rd    = 5'd7;
      bus.alu_rd   = 5'd7;
      bus.alu_data = 32'h77;
      tick();
      n_assert++;
      if (bus.rf_w_en !== 1'b1 || bus.rf_wreg !== 5'd7 || bus.rf_wdata !== 32'h77 || bus.busy !== 32'h80) begin
         $display("FAIL set_wins: w_en=%b wreg=%0d wdata=%h busy=%h, want 1/7/00000077/00000080",
                  bus.rf_w_en, bus.rf_wreg, bus.rf_wdata, bus.busy);
         n_fail++;
      end
      bus.sb_set   = 1'b0;
      bus.alu_data = 32'h78;
      tick();
      n_assert++;
      if (bus.busy !== 32'h0 || bus.rf_wdata !== 32'h78) begin
         $display("FAIL r7_clear: busy=%h wdata=%h, want 0/00000078", bus.busy, bus.rf_wdata);
         n_fail++;
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_starvation;
      int item;
      logic [4:0] exp_rd;
      logic [31:0] exp_data;
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 5'd10;
      bus.ld_data  = 32'h1010;
      tick();
      bus.ld_valid = 1'b0;
      item = 0;
      for (int c = 0; c < 6; c++) begin
         bus.alu_valid = 1'b1;
         bus.alu_rd    = 5'(11 + item);
         bus.alu_data  = 32'h2000 + 32'(item);
         n_assert++;
         if (bus.alu_ready !== (c != 4)) begin
            $display("FAIL starve_alu_ready%0d: got %b, want %b", c, bus.alu_ready, (c != 4));
            n_fail++;
         end
         tick();
         if (c != 4) item++;
         if (c == 4) begin
            exp_rd   = 5'd10;
            exp_data = 32'h1010;
         end else begin
            exp_rd   = 5'(11 + (c < 4 ? c : 4));
            exp_data = 32'h2000 + 32'(c < 4 ? c : 4);
         end
         n_assert++;
         if (bus.rf_w_en !== 1'b1 || bus.rf_wreg !== exp_rd || bus.rf_wdata !== exp_data) begin
            $display("FAIL starve_write%0d: w_en=%b wreg=%0d wdata=%h, want 1/%0d/%h",
                     c, bus.rf_w_en, bus.rf_wreg, bus.rf_wdata, exp_rd, exp_data);
            n_fail++;
         end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_async_reset;
      bus.sb_set    = 1'b1;
      bus.sb_rd     = 5'd3;
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd0;
      for (int i = 0; i < 3; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_rd    = 5'(20 + i);
         bus.ld_data  = 32'h20 + 32'(i);
         if (i == 2) begin
            bus.alu_rd   = 5'd25;
            bus.alu_data = 32'h55;
         end
         tick();
         bus.sb_set = 1'b0;
      end
      idle_inputs();
      n_assert++;
      if (bus.rf_w_en !== 1'b1 || bus.busy !== 32'h8) begin
         $display("FAIL pre_reset: w_en=%b busy=%h, want 1/00000008", bus.rf_w_en, bus.busy);
         n_fail++;
      end
      #2 rst = 1'b1;
      #1;
      n_assert++;
      if (bus.rf_w_en !== 1'b0 || bus.rf_wreg !== 5'd0 || bus.rf_wdata !== 32'h0 || bus.busy !== 32'h0
          || bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
         $display("FAIL async_reset: w_en=%b wreg=%0d wdata=%h busy=%h ld_ready=%b alu_ready=%b, want zeros/1/1",
                  bus.rf_w_en, bus.rf_wreg, bus.rf_wdata, bus.busy, bus.ld_ready, bus.alu_ready);
         n_fail++;
      end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_assert++;
         if (bus.rf_w_en !== 1'b0) begin
            $display("FAIL dropped_load_written%0d: w_en=%b wreg=%0d wdata=%h, want w_en 0",
                     c, bus.rf_w_en, bus.rf_wreg, bus.rf_wdata);
            n_fail++;
         end
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      test_reset();
      test_scoreboard();
      test_load_fifo();
      test_reg0_and_set_wins();
      test_starvation();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
